tri_bus_reader: RTL and testbench
=================================

TRI_BUS_READER -- requirements
Module: tri_bus_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the bit width of the shared bus and of the output data.
REQ-002 Parameter DEPTH, default 4, power of two, SHALL set the number of receive FIFO entries.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 bus_data  input  DATA_WIDTH  SHALL carry the shared bus value, driven by a tri-state writer while that writer's enable is high.
REQ-006 bus_en  input  1  SHALL be the writer's drive enable, synchronous to clk; high means bus_data is valid.
REQ-007 bus_ack  output  1  SHALL be a one-cycle pulse telling the writer that its word was accepted.
REQ-008 out_data  output  DATA_WIDTH  SHALL carry the FIFO head word.
REQ-009 out_valid  output  1  SHALL be high when the FIFO is not empty.
REQ-010 out_ready  input  1  SHALL be the consumer's ready signal; a pop occurs when out_valid and out_ready are both high.
REQ-011 overflow  output  1  SHALL be a sticky flag that sets when a word is dropped.
REQ-012 ovf_clr  input  1  SHALL clear overflow synchronously.

Function
REQ-013 The FSM SHALL have the states IDLE, ACK and WAIT_REL.
REQ-014 In IDLE, a rising edge on bus_en (bus_en high while its registered copy is low) SHALL capture bus_data that same cycle.
- If the FIFO is not full, or a pop occurs in the same cycle, the word SHALL be pushed and the FSM SHALL go to ACK.
- Otherwise the word SHALL be dropped, overflow SHALL be set, and the FSM SHALL go to WAIT_REL.
REQ-015 ACK SHALL assert bus_ack for exactly one cycle and then go to WAIT_REL.
REQ-016 WAIT_REL SHALL return to IDLE on the first cycle in which bus_en is low.
- Each bus_en assertion SHALL capture exactly one word, regardless of how long bus_en stays high.
REQ-017 The FIFO SHALL be first-in, first-out.
- Read and write pointers SHALL be log2(DEPTH) bits wide and SHALL wrap modulo DEPTH.
- The count SHALL be log2(DEPTH)+1 bits wide.
REQ-018 out_data SHALL equal the head entry combinationally; when the FIFO is empty its value is don't-care.
REQ-019 On a simultaneous push and pop, the count SHALL stay unchanged.
- When the FIFO is full, that push SHALL succeed without setting overflow.
- When the FIFO is empty, the push SHALL be ignored for that cycle's pop.
REQ-020 Latency from the capturing edge to out_valid high SHALL be one clock cycle.
REQ-021 If ovf_clr is high in the same cycle that a drop occurs, overflow SHALL remain set (set has priority).
REQ-022 When out_ready is high while the FIFO is empty, no state SHALL change.

Reset
REQ-023 Asserting rst SHALL immediately force the following, including mid-transfer:
- FSM to IDLE;
- pointers and count to 0;
- the bus_en edge register to 0;
- bus_ack, out_valid and overflow to 0.
REQ-024 FIFO storage contents SHALL not require reset.
REQ-025 If bus_en is already high when rst is released, the first cycle after release SHALL count as a rising edge.

Configuration
REQ-026 With macro TRI_BUS_READER_PARITY_EN defined:
- an input bus_par (1 bit, even parity over bus_data) SHALL be added;
- an output par_err (sticky, cleared by ovf_clr and by rst) SHALL be added;
- a captured word with bad parity SHALL set par_err, SHALL be dropped without bus_ack, and the FSM SHALL go to WAIT_REL.
REQ-027 Without TRI_BUS_READER_PARITY_EN, bus_par and par_err SHALL be absent, and every captured word SHALL be treated as good.

Verification
REQ-028 Single word: bus_en high for 3 cycles with bus_data=8'hA5 and out_ready=0 -> exactly one bus_ack pulse, out_valid=1, out_data=8'hA5, count=1.
REQ-029 Fill and overflow: 5 separate bus_en pulses carrying 8'h01..8'h05 with out_ready=0 -> 4 acks, overflow=1 after the fifth pulse; popping then yields 01, 02, 03, 04.
REQ-030 Full with simultaneous pop: FIFO full with head 8'h01, a bus_en rise carrying 8'h10 while out_ready=1 -> 8'h10 accepted, bus_ack pulses, overflow stays 0, count stays 4.
REQ-031 Reset mid-operation: rst asserted during the ACK state with 2 words stored -> bus_ack=0, out_valid=0 and overflow=0 in the same cycle; after release with bus_en high, a new capture occurs on the first cycle.
REQ-032 Pointer wrap: 10 words pushed and popped interleaved at DEPTH=4 -> output order equals input order through the pointer wrap.
REQ-033 With TRI_BUS_READER_PARITY_EN defined: bus_data=8'h03 with bus_par=1 -> par_err=1, no bus_ack, count unchanged; bus_data=8'h03 with bus_par=0 -> accepted.

Source files
------------

// File: rtl/tri_bus_reader.sv
// Tri-state bus reader: captures one word per bus_en assertion into a receive FIFO and acks it.
// Optional parity checking of the captured word is enabled by defining TRI_BUS_READER_PARITY_EN.
module tri_bus_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] bus_data,
    input  logic                  bus_en,
`ifdef TRI_BUS_READER_PARITY_EN
    input  logic                  bus_par,
    output logic                  par_err,
`endif
    output logic                  bus_ack,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = DEPTH[AW:0];

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACK      = 2'd1,
        S_WAIT_REL = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_en_d;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  r_overflow;
    logic                  w_rise;
    logic                  w_par_ok;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

`ifdef TRI_BUS_READER_PARITY_EN
    logic                  r_par_err;
    logic                  w_par_bad;

    function automatic logic even_parity_ok(input logic [DATA_WIDTH-1:0] d, input logic p);
        return ((^d) == p);
    endfunction

    assign w_par_ok  = even_parity_ok(bus_data, bus_par);
    assign w_par_bad = (r_state == S_IDLE) && w_rise && !w_par_ok;
    assign par_err   = r_par_err;

    // Sticky parity error; a new bad word wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_par_bad) begin
            r_par_err <= 1'b1;
        end else if (ovf_clr) begin
            r_par_err <= 1'b0;
        end
    end
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_rise    = bus_en && !r_en_d;
    assign w_full    = (r_count == C_FULL);
    assign w_pop     = (r_count != {(AW+1){1'b0}}) && out_ready;
    assign out_valid = (r_count != {(AW+1){1'b0}});
    assign out_data  = r_mem[r_rd_ptr];
    assign bus_ack   = (r_state == S_ACK);
    assign overflow  = r_overflow;

    // Next-state and capture decisions; a pop in the same cycle frees room for a push when full.
    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    if (!w_par_ok) begin
                        w_next_state = S_WAIT_REL;
                    end else if (!w_full || w_pop) begin
                        w_push       = 1'b1;
                        w_next_state = S_ACK;
                    end else begin
                        w_drop       = 1'b1;
                        w_next_state = S_WAIT_REL;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ACK: begin
                w_next_state = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!bus_en) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_WAIT_REL;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register and bus_en edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_en_d  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_en_d  <= bus_en;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus_data;
        end
    end

    // Sticky overflow; a drop wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tri_bus_reader.sv
// Directed self-checking bench for tri_bus_reader (DATA_WIDTH=8, DEPTH=4).
// Parity checks are included when TRI_BUS_READER_PARITY_EN is defined.
module tb_tri_bus_reader;

    logic       clk;
    logic       rst;
    logic [7:0] bus_data;
    logic       bus_en;
    logic       bus_ack;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic       ovf_clr;
`ifdef TRI_BUS_READER_PARITY_EN
    logic       bus_par;
    logic       par_err;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int acks;

    tri_bus_reader #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_data  (bus_data),
        .bus_en    (bus_en),
`ifdef TRI_BUS_READER_PARITY_EN
        .bus_par   (bus_par),
        .par_err   (par_err),
`endif
        .bus_ack   (bus_ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One-cycle bus_en pulse, then wait for the FSM to return to IDLE.
    task automatic send_word(input logic [7:0] d, input logic rdy, input logic clr, output int n_ack);
        bus_data  = d;
`ifdef TRI_BUS_READER_PARITY_EN
        bus_par   = ^d;
`endif
        bus_en    = 1'b1;
        out_ready = rdy;
        ovf_clr   = clr;
        tick();
        n_ack     = int'(bus_ack);
        bus_en    = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick();
        n_ack    += int'(bus_ack);
        tick();
        n_ack    += int'(bus_ack);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, out_data}, {24'd0, exp});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int a;
        rst       = 1'b1;
        bus_data  = 8'h00;
        bus_en    = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
`ifdef TRI_BUS_READER_PARITY_EN
        bus_par   = 1'b0;
`endif
        #2;
        check("rst_ack",   32'(bus_ack),   32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single word held for three cycles
        bus_data = 8'hA5;
`ifdef TRI_BUS_READER_PARITY_EN
        bus_par  = ^bus_data;
`endif
        bus_en   = 1'b1;
        tick();
        check("single_latency_valid", 32'(out_valid), 32'd1);
        a = int'(bus_ack);
        tick();
        a += int'(bus_ack);
        tick();
        a += int'(bus_ack);
        bus_en = 1'b0;
        tick();
        a += int'(bus_ack);
        tick();
        check("single_acks",  32'(a),                 32'd1);
        check("single_data",  {24'd0, out_data},      32'h0000_00A5);
        check("single_count", 32'(dut.r_count),       32'd1);
        pop_check("single_pop", 8'hA5);
        check("single_empty", 32'(out_valid), 32'd0);

        // Fill and overflow
        acks = 0;
        for (int i = 1; i <= 4; i++) begin
            send_word(8'(i), 1'b0, 1'b0, a);
            acks += a;
        end
        check("fill_ovf_before", 32'(overflow), 32'd0);
        send_word(8'h05, 1'b0, 1'b0, a);
        acks += a;
        check("fill_acks",  32'(acks),            32'd4);
        check("fill_ovf",   32'(overflow),        32'd1);
        check("fill_count", 32'(dut.r_count),     32'd4);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Drop coinciding with clear: set wins
        send_word(8'h06, 1'b0, 1'b1, a);
        check("set_prio_ack", 32'(a),        32'd0);
        check("set_prio_ovf", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // Full with simultaneous pop
        send_word(8'h10, 1'b1, 1'b0, a);
        check("fullpop_ack",   32'(a),            32'd1);
        check("fullpop_ovf",   32'(overflow),     32'd0);
        check("fullpop_count", 32'(dut.r_count),  32'd4);
        pop_check("fullpop_0", 8'h02);
        pop_check("fullpop_1", 8'h03);
        pop_check("fullpop_2", 8'h04);
        pop_check("fullpop_3", 8'h10);
        check("fullpop_empty", 32'(out_valid), 32'd0);

        // Reset during ACK with two words stored
        for (int i = 0; i < 5; i++) begin
            send_word(8'h41 + 8'(i), 1'b0, 1'b0, a);
        end
        check("rstmid_ovf_pre", 32'(overflow), 32'd1);
        pop_check("rstmid_p0", 8'h41);
        pop_check("rstmid_p1", 8'h42);
        pop_check("rstmid_p2", 8'h43);
        bus_data = 8'h46;
`ifdef TRI_BUS_READER_PARITY_EN
        bus_par  = ^bus_data;
`endif
        bus_en   = 1'b1;
        tick();
        check("rstmid_ack_pre",   32'(bus_ack),       32'd1);
        check("rstmid_count_pre", 32'(dut.r_count),   32'd2);
        rst = 1'b1;
        #1;
        check("rstmid_ack",   32'(bus_ack),     32'd0);
        check("rstmid_valid", 32'(out_valid),   32'd0);
        check("rstmid_ovf",   32'(overflow),    32'd0);
        bus_data = 8'h55;
`ifdef TRI_BUS_READER_PARITY_EN
        bus_par  = ^bus_data;
`endif
        tick();
        rst = 1'b0;
        tick();
        check("rstrel_ack",   32'(bus_ack),     32'd1);
        check("rstrel_valid", 32'(out_valid),   32'd1);
        check("rstrel_data",  {24'd0, out_data}, 32'h0000_0055);
        bus_en = 1'b0;
        tick();
        tick();
        pop_check("rstrel_pop", 8'h55);

        // Interleaved push/pop through pointer wrap
        for (int i = 0; i < 10; i++) begin
            send_word(8'h60 + 8'(i), 1'b0, 1'b0, a);
            if (i > 0) begin
                pop_check($sformatf("wrap_%0d", i - 1), 8'h60 + 8'(i - 1));
            end
        end
        pop_check("wrap_9", 8'h69);
        check("wrap_empty", 32'(out_valid), 32'd0);

        // Ready while empty changes nothing
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("emptyrdy_count", 32'(dut.r_count), 32'd0);
        send_word(8'h77, 1'b0, 1'b0, a);
        check("emptyrdy_data",  {24'd0, out_data}, 32'h0000_0077);
        check("emptyrdy_count1", 32'(dut.r_count), 32'd1);
        pop_check("emptyrdy_pop", 8'h77);

`ifdef TRI_BUS_READER_PARITY_EN
        // Bad parity dropped without ack, then good parity accepted
        bus_data = 8'h03;
        bus_par  = 1'b1;
        bus_en   = 1'b1;
        tick();
        check("par_bad_ack",   32'(bus_ack),      32'd0);
        check("par_bad_err",   32'(par_err),      32'd1);
        check("par_bad_count", 32'(dut.r_count),  32'd0);
        bus_en = 1'b0;
        tick();
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("par_clr", 32'(par_err), 32'd0);
        send_word(8'h03, 1'b0, 1'b0, a);
        check("par_good_ack", 32'(a), 32'd1);
        pop_check("par_good_data", 8'h03);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
